// File: rtl/irq_request_latch_pkg.sv
// irq_pkg: shared constants and types for the irq_request_latch block.
// The optional sticky lost-edge detector is enabled with IRQ_OVERFLOW_EN.
package irq_pkg;

  localparam int N_REQ   = 4;
  localparam int INDEX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARB     = 2'd1,
    PRESENT = 2'd2
  } irq_state_t;

  typedef logic [N_REQ-1:0]   req_vec_t;
  typedef logic [INDEX_W-1:0] irq_idx_t;

  // One-hot vector selecting the pending bit behind a request index.
  function automatic req_vec_t idx_to_onehot(irq_idx_t idx);
    return req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/irq_request_latch_if.sv
// Valid/ready handshake carrying the winning request index to the consumer.
interface irq_request_latch_if;
  import irq_pkg::*;

  logic     irq_valid;
  irq_idx_t irq_idx;
  logic     irq_ready;

  modport master (output irq_valid, output irq_idx, input irq_ready);
  modport slave  (input irq_valid, input irq_idx, output irq_ready);

endinterface

// File: rtl/irq_request_latch_edge_detect.sv
// irq_edge_detect: rising-edge detector for the request lines. prev resets
// to 0, so a line already high at reset release counts as an edge.
module irq_edge_detect
  import irq_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  req_vec_t req_in,
  output req_vec_t req_edge
);

  req_vec_t prev;

  // Remember last cycle's request levels.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) prev <= '0;
    else        prev <= req_in;
  end

  assign req_edge = req_in & ~prev;

endmodule

// File: rtl/irq_request_latch.sv
// irq_request_latch: captures request edges into a pending register, exposes
// the masked pending vector to an external priority encoder, and presents the
// encoder's winning index over a valid/ready handshake.
// Optional feature: define IRQ_OVERFLOW_EN to build the sticky overflow flag.
module irq_request_latch
  import irq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  req_vec_t               req_in,
  input  req_vec_t               mask,
  output req_vec_t               pend,
  input  irq_idx_t               enc_idx,
  irq_request_latch_if.master    irq,
  output logic                   overflow
);

  irq_state_t state, state_nxt;
  req_vec_t   pending;
  req_vec_t   req_edge;
  req_vec_t   clr_vec;
  irq_idx_t   idx_q;
  logic       accept;

  irq_edge_detect u_edge_detect (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .req_edge (req_edge)
  );

  assign accept  = (state == PRESENT) && irq.irq_ready;
  assign clr_vec = accept ? idx_to_onehot(idx_q) : '0;

  // Pending register: clear the accepted bit, then OR in new edges.
  always_ff @(posedge clk) begin
    // NOTE: the edge term is applied after the clear, so a new edge on the
    // bit being accepted keeps that bit pending.
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr_vec) | req_edge;
  end

  // Masked bits stay in pending; they are only hidden from the encoder.
  assign pend = pending & ~mask;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (|pend) state_nxt = ARB;
      ARB:     state_nxt = PRESENT;
      PRESENT: if (irq.irq_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the encoder result during ARB; it stays frozen while presented.
  always_ff @(posedge clk) begin
    if (!rst_n)              idx_q <= '0;
    else if (state == ARB)   idx_q <= enc_idx;
  end

  assign irq.irq_valid = (state == PRESENT);
  assign irq.irq_idx   = idx_q;

`ifdef IRQ_OVERFLOW_EN
  logic overflow_q;

  // Sticky flag: an edge arrived on a bit that was already pending and not
  // being cleared this cycle, so one request was lost.
  always_ff @(posedge clk) begin
    if (!rst_n)                                    overflow_q <= 1'b0;
    else if (|(req_edge & pending & ~clr_vec))     overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_irq_request_latch.sv
// Self-checking bench for irq_request_latch. The parent-level priority
// encoder is modelled here, and a cycle-level reference model tracks the
// expected pending set, handshake and overflow flag.
module tb_irq_request_latch;
  import irq_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  req_vec_t req_in;
  req_vec_t mask;
  req_vec_t pend;
  irq_idx_t enc_idx;
  logic     overflow;

  irq_request_latch_if irq ();

  always #5 clk = ~clk;

  // Parent-level priority encoder: highest set bit of pend wins.
  always_comb begin
    enc_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pend[i]) enc_idx = irq_idx_t'(i);
  end

  irq_request_latch dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .mask     (mask),
    .pend     (pend),
    .enc_idx  (enc_idx),
    .irq      (irq),
    .overflow (overflow)
  );

  int passed = 0;
  int total  = 0;

  // Reference model state.
  bit       m_pend [N_REQ];
  bit       m_prev [N_REQ];
  bit       m_valid;
  bit       m_arbitrating;
  int       m_idx;
  bit       m_ovf;
  int       accepted[$];

  function automatic int highest_visible(input req_vec_t msk);
    int w;
    w = -1;
    for (int i = 0; i < N_REQ; i++)
      if (m_pend[i] && !msk[i]) w = i;
    return w;
  endfunction

  function automatic logic [7:0] got_vec();
    return {irq.irq_valid, irq.irq_idx, pend, overflow};
  endfunction

  function automatic logic [7:0] want_vec();
    req_vec_t vis;
    for (int i = 0; i < N_REQ; i++) vis[i] = m_pend[i] && !mask[i];
    return {m_valid, irq_idx_t'(m_idx), vis, m_ovf};
  endfunction

  // Drive one cycle of inputs and advance the reference model at the edge.
  task automatic cycle(input req_vec_t r, input req_vec_t m, input logic rdy);
    int  w;
    bit  acc;
    bit  rise;
    @(negedge clk);
    req_in        = r;
    mask          = m;
    irq.irq_ready = rdy;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        m_pend[i] = 1'b0;
        m_prev[i] = 1'b0;
      end
      m_valid = 1'b0; m_arbitrating = 1'b0; m_idx = 0; m_ovf = 1'b0;
    end else begin
      w   = highest_visible(m);
      acc = m_valid && rdy;
      if (acc) accepted.push_back(m_idx);
      for (int i = 0; i < N_REQ; i++) begin
        rise = r[i] && !m_prev[i];
`ifdef IRQ_OVERFLOW_EN
        if (rise && m_pend[i] && !(acc && i == m_idx)) m_ovf = 1'b1;
`endif
        if (rise)                 m_pend[i] = 1'b1;
        else if (acc && i == m_idx) m_pend[i] = 1'b0;
        m_prev[i] = r[i];
      end
      if (m_valid) begin
        if (rdy) m_valid = 1'b0;
      end else if (m_arbitrating) begin
        m_idx         = (w < 0) ? 0 : w;
        m_arbitrating = 1'b0;
        m_valid       = 1'b1;
      end else if (w >= 0) begin
        m_arbitrating = 1'b1;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cycle('0, '0, 1'b0);
    cycle('0, '0, 1'b0);
    rst_n = 1'b1;
    accepted.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle(4'hF, '0, 1'b0);
      total++;
      if (got_vec() !== 8'h00) $display("FAIL reset_hold got=%b want=%b", got_vec(), 8'h00);
      else passed++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(4'hF, '0, 1'b0);
      total++;
      if (got_vec() !== want_vec()) $display("FAIL reset_release got=%b want=%b", got_vec(), want_vec());
      else passed++;
      if (i == 0) begin
        total++;
        if (pend !== 4'hF) $display("FAIL reset_first_edge pend got=%b want=1111", pend);
        else passed++;
      end
    end
  endtask

  task automatic test_single();
    req_vec_t rs [6];
    logic     rd [6];
    apply_reset();
    rs = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
    rd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      cycle(rs[i], '0, rd[i]);
      total++;
      if (got_vec() !== want_vec()) $display("FAIL single[%0d] got=%b want=%b", i, got_vec(), want_vec());
      else passed++;
      if (i == 3) begin
        total++;
        if (irq.irq_valid !== 1'b1 || irq.irq_idx !== 2'd2)
          $display("FAIL single_present got valid=%b idx=%0d want valid=1 idx=2", irq.irq_valid, irq.irq_idx);
        else passed++;
      end
    end
  endtask

  task automatic test_priority();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(4'b1010, '0, 1'b1);
      total++;
      if (got_vec() !== want_vec()) $display("FAIL priority[%0d] got=%b want=%b", i, got_vec(), want_vec());
      else passed++;
      if (i == 5) begin
        total++;
        if (irq.irq_valid !== 1'b1 || irq.irq_idx !== 2'd1)
          $display("FAIL priority_second got valid=%b idx=%0d want valid=1 idx=1", irq.irq_valid, irq.irq_idx);
        else passed++;
      end
    end
    total++;
    if (accepted.size() != 2 || accepted[0] != 3 || accepted[1] != 1 || pend !== 4'b0000)
      $display("FAIL priority_order got n=%0d pend=%b want order 3,1 pend=0000", accepted.size(), pend);
    else passed++;
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(4'b1001, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1001, 4'b1000, 1'b0);
      total++;
      if (irq.irq_valid !== 1'b1 || irq.irq_idx !== 2'd3 || got_vec() !== want_vec())
        $display("FAIL backpressure[%0d] got=%b want=%b", i, got_vec(), want_vec());
      else passed++;
    end
    for (int i = 0; i < 6; i++) begin
      cycle(4'b1001, '0, 1'b1);
      total++;
      if (got_vec() !== want_vec()) $display("FAIL backpressure_drain[%0d] got=%b want=%b", i, got_vec(), want_vec());
      else passed++;
    end
  endtask

  task automatic test_collision();
    req_vec_t rs [8];
    logic     rd [8];
    apply_reset();
    rs = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
    rd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      cycle(rs[i], '0, rd[i]);
      total++;
      if (got_vec() !== want_vec()) $display("FAIL collision[%0d] got=%b want=%b", i, got_vec(), want_vec());
      else passed++;
      if (i == 4) begin
        total++;
        if (pend[3] !== 1'b1) $display("FAIL collision_set_wins pend=%b want bit3=1", pend);
        else passed++;
      end
      if (i == 6) begin
        total++;
        if (irq.irq_valid !== 1'b1 || irq.irq_idx !== 2'd3)
          $display("FAIL collision_represent got valid=%b idx=%0d want valid=1 idx=3", irq.irq_valid, irq.irq_idx);
        else passed++;
      end
    end
  endtask

  task automatic test_overflow();
    req_vec_t rs [9];
    logic     rd [9];
    logic     exp_ovf;
`ifdef IRQ_OVERFLOW_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    apply_reset();
    rs = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    rd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      cycle(rs[i], '0, rd[i]);
      total++;
      if (got_vec() !== want_vec()) $display("FAIL overflow[%0d] got=%b want=%b", i, got_vec(), want_vec());
      else passed++;
      if (i >= 4) begin
        total++;
        if (overflow !== exp_ovf) $display("FAIL overflow_sticky[%0d] got=%b want=%b", i, overflow, exp_ovf);
        else passed++;
      end
    end
    apply_reset();
    total++;
    if (overflow !== 1'b0) $display("FAIL overflow_reset got=%b want=0", overflow);
    else passed++;
  endtask

  task automatic test_random();
    req_vec_t r, m;
    logic     rdy;
    apply_reset();
    r = '0;
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 2) == 0) r = req_vec_t'($urandom);
      m   = ($urandom_range(0, 3) == 0) ? req_vec_t'($urandom) : '0;
      rdy = ($urandom_range(0, 1) == 1);
      cycle(r, m, rdy);
      total++;
      if (got_vec() !== want_vec()) $display("FAIL random[%0d] got=%b want=%b", i, got_vec(), want_vec());
      else passed++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    req_in        = '0;
    mask          = '0;
    irq.irq_ready = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_backpressure();
    test_collision();
    test_overflow();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/irq_request_latch.md
# irq_request_latch

Request-capture stage directly upstream of `priority_encoder`. It detects rising edges on N_REQ request lines and holds them in a pending register. The masked pending vector drives the encoder's `a` input, and the block takes the encoder's `y` back as `enc_idx`. The winning index is presented to the consumer over a valid/ready handshake, and the pending bit is cleared on acceptance.

## Interface
- `N_REQ`, 4, number of request lines; must equal the encoder input width (4 in this revision).
- `INDEX_W`, `$clog2(N_REQ)` = 2, width of the index; derived, not overridden.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_in`  in  N_REQ  request lines, synchronous to `clk`; a 0→1 transition sets the pending bit.
- `mask`  in  N_REQ  1 = line masked; the pending bit is kept but hidden from `pend`.
- `pend`  out  N_REQ  `pending & ~mask`, combinational; connects to encoder `a`.
- `enc_idx`  in  INDEX_W  encoder `y`; highest set bit of `pend` wins.
- `irq_valid`  out  1  presented index valid.
- `irq_idx`  out  INDEX_W  presented request index.
- `irq_ready`  in  1  consumer accepts when high with `irq_valid`.
- `overflow`  out  1  sticky lost-edge flag (see Configuration).

## Operation
- Edge detect: `prev` register samples `req_in` each cycle. `edge = req_in & ~prev`. `edge[i]` sets `pending[i]` at the next clock.
- FSM states are IDLE, ARB and PRESENT.
  - IDLE: when `|pend` = 1, go to ARB. Otherwise stay in IDLE.
  - ARB: latch `enc_idx` into `irq_idx` and go to PRESENT. This cycle lets the encoder settle on a registered `pend`.
  - PRESENT: `irq_valid` = 1.
    - While waiting, `irq_idx` is held stable and `irq_valid` is never withdrawn. This holds even if `mask` or `pending` change.
    - When `irq_valid & irq_ready`: clear `pending[irq_idx]` and go to IDLE.
- Set/clear collision: if `edge[i]` coincides with the acceptance clear of bit `i`, set wins and the bit stays pending.
- Masked bits are retained. Unmasking a pending bit makes it visible on `pend` in the same cycle.
- If all pending bits become masked while in ARB, `irq_idx` is still latched and presented. `enc_idx` is then don't-care, so the consumer must tolerate this. `pend` being 0 in ARB does not occur in normal use.

## Timing
- Reset (rst_n low at a clock edge) forces: `pending` = 0, `prev` = 0, state = IDLE, `irq_valid` = 0, `irq_idx` = 0, `overflow` = 0.
- Because `prev` resets to 0, a line held high through reset release registers as an edge on the first active cycle.
- Latency is counted in clock edges. Suppose the edge is sampled at clock k:
  - `pend` bit visible after k.
  - ARB entered at k+1.
  - `irq_valid` = 1 after k+2.
- Acceptance at clock m: after m, `irq_valid` = 0 and the bit is clear. The next index, if any is pending, is valid after m+2.
- Minimum spacing between presentations is 3 cycles.
- Reset mid-handshake drops the presented request with no acceptance.

## Configuration
- `IRQ_OVERFLOW_EN` defined: `overflow` sets when `edge[i]` occurs while `pending[i]` is already 1 and is not being cleared in that cycle. It stays set until reset.
- `IRQ_OVERFLOW_EN` undefined: `overflow` is tied to 0 and no detection logic is built.

## Structure
- Package `irq_pkg` contains:
  - constants `N_REQ` and `INDEX_W`;
  - typedef `irq_state_t` (enum IDLE, ARB, PRESENT);
  - typedefs `req_vec_t` and `irq_idx_t`.
- Sub-module `irq_edge_detect` owns the `prev` register and produces `edge`. It takes `clk`, `rst_n`, `req_in` and outputs `edge`.
- `priority_encoder` is instantiated outside this block, at the parent level.

## Test plan
- Reset: `rst_n` = 0 for 2 cycles with `req_in` = 4'hF → `irq_valid` = 0, `pend` = 0, `overflow` = 0. On the first active cycle, `pend` = 4'hF one cycle later.
- Single request: `req_in` 0→4'b0100, `mask` = 0 → `pend` = 4'b0100 after 1 clock, `irq_valid` = 1 with `irq_idx` = 2 two clocks later. Then `irq_ready` = 1 → next cycle `pend` = 0, `irq_valid` = 0.
- Priority order: `req_in` 0→4'b1010 simultaneously → `irq_idx` = 3 first. After acceptance, `irq_idx` = 1 valid 2 clocks after the ack. Then `pend` = 0.
- Backpressure: `irq_ready` = 0 for 5 cycles in PRESENT while `mask` changes to 4'b1000 → `irq_valid` and `irq_idx` are held constant for all 5 cycles.
- Collision: a new edge on bit 3 in the same cycle as acceptance of index 3 → `pending[3]` stays 1, and `irq_idx` = 3 is presented again 2 clocks later.
- Overflow: two edges on bit 0 (1→0→1) with no acceptance between them → `overflow` = 1 and stays 1 until reset with `IRQ_OVERFLOW_EN` defined; `overflow` stays 0 without it.
